// File: rtl/float_acc_reduce_pkg.sv
// Shared defaults and reduction-controller state encoding.
package float_acc_reduce_pkg;

    localparam int DEF_D_LEN   = 32;
    localparam int DEF_CELL_N  = 8;
    localparam int DEF_ADD_LAT = 3;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        TREE = 2'd1,
        FOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/float_acc_reduce_if.sv
// Input beat stream and result handshake of the accumulator.
interface float_acc_reduce_if
    import float_acc_reduce_pkg::*;
#(
    parameter int D_LEN  = DEF_D_LEN,
    parameter int CELL_N = DEF_CELL_N,
    parameter int CNT_W  = DEF_CNT_W
);
    logic [CELL_N*D_LEN-1:0] in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [D_LEN-1:0]        out_sum;
    logic [CNT_W-1:0]        out_cnt;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_cnt, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_cnt, out_valid
    );
endinterface

// File: rtl/acc_lane_tag.sv
// Per-lane liveness tag pipeline matched to the adder latency, plus the
// operand gating that turns dead slots into +0.
module acc_lane_tag #(
    parameter int D_LEN   = 32,
    parameter int ADD_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [D_LEN-1:0]   a_in,
    input  logic               a_vld,
    input  logic [D_LEN-1:0]   b_in,
    input  logic               b_vld,
    input  logic               t_in,
    output logic [D_LEN-1:0]   a_op,
    output logic [D_LEN-1:0]   b_op,
    output logic               t_out,
    output logic [ADD_LAT-1:0] t_nxt
);
    logic [ADD_LAT-1:0] tag_q, tag_d;

    // Shift a new tag in each cycle; clear wipes every slot.
    always_comb begin
        tag_d = '0;
        if (!clr) begin
            tag_d[0] = t_in;
            for (int k = 1; k < ADD_LAT; k++) tag_d[k] = tag_q[k-1];
        end
    end

    // Tag register, discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= '0;
        else        tag_q <= tag_d;
    end

    assign t_out = tag_q[ADD_LAT-1];
    assign t_nxt = tag_d;
    assign a_op  = a_vld ? a_in : '0;
    assign b_op  = b_vld ? b_in : '0;
endmodule

// File: rtl/float_adder.sv
// Pipelined binary32-style float adder: round-to-nearest-even, denormals
// flushed to +0, overflow to infinity. Result appears LAT cycles later.
module float_adder #(
    parameter int D_LEN = 32,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic [D_LEN-1:0] a,
    input  logic [D_LEN-1:0] b,
    output logic [D_LEN-1:0] y
);
    localparam int EW  = 8;
    localparam int MW  = D_LEN - 1 - EW;
    localparam int MW1 = MW + 1;
    localparam int XW  = MW + 4;   // hidden bit + mantissa + guard/round/sticky

    logic [D_LEN-1:0] big, sml, res;
    logic [EW-1:0]    eb, es;
    logic [XW-1:0]    bx, sx, lost_mask, norm;
    logic [XW:0]      sum;
    logic [MW:0]      mant_r;
    logic             sticky, rup, found;
    int               ediff, lz, exp_r;
    logic [D_LEN-1:0] pipe_q [LAT];

    // Align, add/subtract, normalise and round one operand pair.
    always_comb begin
        big = a; sml = b;
        if (a[D_LEN-2:0] < b[D_LEN-2:0]) begin
            big = b; sml = a;
        end
        eb = big[D_LEN-2:MW];
        es = sml[D_LEN-2:MW];
        bx = (eb != '0) ? {1'b1, big[MW-1:0], 3'b000} : '0;
        sx = (es != '0) ? {1'b1, sml[MW-1:0], 3'b000} : '0;
        ediff     = int'(eb) - int'(es);
        lost_mask = '0;
        sticky    = 1'b0;
        if (ediff >= XW) begin
            sticky = |sx;
            sx     = '0;
        end else begin
            lost_mask = (XW'(1) << ediff) - XW'(1);
            sticky    = |(sx & lost_mask);
            sx        = sx >> ediff;
        end
        sx[0] = sx[0] | sticky;
        sum = (big[D_LEN-1] ^ sml[D_LEN-1]) ? ({1'b0, bx} - {1'b0, sx})
                                            : ({1'b0, bx} + {1'b0, sx});
        lz    = 0;
        found = 1'b0;
        exp_r = int'(eb);
        if (sum[XW]) begin
            norm    = sum[XW:1];
            norm[0] = norm[0] | sum[0];
            exp_r   = exp_r + 1;
        end else begin
            for (int k = XW - 1; k >= 0; k--) begin
                if (!found) begin
                    if (sum[k]) found = 1'b1;
                    else        lz = lz + 1;
                end
            end
            norm  = sum[XW-1:0] << lz;
            exp_r = exp_r - lz;
        end
        rup    = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant_r = {1'b0, norm[XW-2:3]} + MW1'(rup);
        if (mant_r[MW]) exp_r = exp_r + 1;
        if (sum == '0 || exp_r <= 0)
            res = '0;
        else if (exp_r >= (1 << EW) - 1)
            res = {big[D_LEN-1], {EW{1'b1}}, {MW{1'b0}}};
        else
            res = {big[D_LEN-1], exp_r[EW-1:0], mant_r[MW-1:0]};
    end

    // Fixed-latency result pipeline; contents are qualified by lane tags.
    always_ff @(posedge clk) begin
        pipe_q[0] <= res;
        for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end

    assign y = pipe_q[LAT-1];
endmodule

// File: rtl/float_acc_reduce.sv
// Streaming float accumulator: per-lane recirculating partial sums, a
// tag-tracked lane tree, then a hold-register fold of lane 0 to one scalar.
module float_acc_reduce
    import float_acc_reduce_pkg::*;
#(
    parameter int D_LEN   = DEF_D_LEN,
    parameter int CELL_N  = DEF_CELL_N,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    float_acc_reduce_if.slave bus
);
    localparam int LVLS   = (CELL_N > 1) ? $clog2(CELL_N) : 1;
    localparam int LW     = (LVLS > 1) ? $clog2(LVLS) : 1;
    localparam int CW     = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam int LIVE_W = $clog2(ADD_LAT + 1);

    state_e             state_q, state_d;
    logic [LW-1:0]      lvl_q, lvl_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LIVE_W-1:0]  live_q, live_d, live_init;
    logic [D_LEN-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [D_LEN-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic                           accept, clr;
    logic [CELL_N-1:0][D_LEN-1:0]   y, a_raw, b_raw, a_op, b_op;
    logic [CELL_N-1:0]              a_vld, b_vld, t_in, t_out;
    logic [CELL_N-1:0][ADD_LAT-1:0] t_nxt;

    assign accept = bus.in_valid & in_ready_q;
    assign clr    = (state_q == DONE) & bus.out_ready;

    // Route operands and tags into each lane according to the current phase.
    always_comb begin : p_steer
        int h;
        a_raw = '0; b_raw = '0; a_vld = '0; b_vld = '0; t_in = '0;
        h = CELL_N >> (int'(lvl_q) + 1);
        case (state_q)
            ACC: begin
                for (int i = 0; i < CELL_N; i++) begin
                    a_raw[i] = bus.in_data[i*D_LEN +: D_LEN];
                    a_vld[i] = accept;
                    b_raw[i] = y[i];
                    b_vld[i] = t_out[i];
                    t_in[i]  = accept | t_out[i];
                end
            end
            TREE: begin
                for (int i = 0; i < CELL_N; i++) begin
                    if (i < h) begin
                        a_raw[i] = y[i];
                        a_vld[i] = t_out[i];
                        b_raw[i] = y[i+h];
                        b_vld[i] = t_out[i+h];
                        t_in[i]  = t_out[i] | t_out[i+h];
                    end
                end
            end
            FOLD: begin
                if (t_out[0] && hold_full_q) begin
                    a_raw[0] = hold_q;
                    a_vld[0] = 1'b1;
                    b_raw[0] = y[0];
                    b_vld[0] = 1'b1;
                    t_in[0]  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Live partials entering FOLD. Lanes above 0 only received dead tags
    // during the final level, so counting all lanes equals counting lane 0.
    always_comb begin : p_live
        int pc;
        pc = 0;
        for (int i = 0; i < CELL_N; i++)
            for (int k = 0; k < ADD_LAT; k++)
                pc = pc + int'(t_nxt[i][k]);
        live_init = LIVE_W'(pc);
    end

    // Controller next state: accumulate, tree levels, fold, result hold.
    always_comb begin : p_next
        state_d     = state_q;
        lvl_d       = lvl_q;
        cyc_d       = cyc_q;
        beat_cnt_d  = beat_cnt_q;
        live_d      = live_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
                    if (bus.in_last) begin
                        lvl_d       = '0;
                        cyc_d       = '0;
                        hold_full_d = 1'b0;
                        if (CELL_N > 1) begin
                            state_d = TREE;
                        end else begin
                            state_d = FOLD;
                            live_d  = live_init;
                        end
                    end
                end
            end
            TREE: begin
                if (cyc_q == CW'(ADD_LAT - 1)) begin
                    cyc_d = '0;
                    if (lvl_q == LW'(LVLS - 1)) begin
                        state_d = FOLD;
                        live_d  = live_init;
                    end else begin
                        lvl_d = lvl_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            FOLD: begin
                if ((live_q == LIVE_W'(1) && hold_full_q) || live_q == '0) begin
                    out_sum_d   = hold_full_q ? hold_q : '0;
                    out_cnt_d   = beat_cnt_q;
                    out_valid_d = 1'b1;
                    hold_full_d = 1'b0;
                    state_d     = DONE;
                end else if (t_out[0]) begin
                    if (!hold_full_q) begin
                        hold_d      = y[0];
                        hold_full_d = 1'b1;
                    end else begin
                        hold_full_d = 1'b0;
                        live_d      = live_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
        in_ready_d = (state_d == ACC);
    end

    // Controller and result registers; reset abandons any reduction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            lvl_q       <= '0;
            cyc_q       <= '0;
            beat_cnt_q  <= '0;
            live_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            cyc_q       <= cyc_d;
            beat_cnt_q  <= beat_cnt_d;
            live_q      <= live_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    for (genvar i = 0; i < CELL_N; i++) begin : g_lane
        acc_lane_tag #(.D_LEN(D_LEN), .ADD_LAT(ADD_LAT)) u_tag (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .a_in  (a_raw[i]),
            .a_vld (a_vld[i]),
            .b_in  (b_raw[i]),
            .b_vld (b_vld[i]),
            .t_in  (t_in[i]),
            .a_op  (a_op[i]),
            .b_op  (b_op[i]),
            .t_out (t_out[i]),
            .t_nxt (t_nxt[i])
        );
        float_adder #(.D_LEN(D_LEN), .LAT(ADD_LAT)) u_add (
            .clk (clk),
            .a   (a_op[i]),
            .b   (b_op[i]),
            .y   (y[i])
        );
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_valid = out_valid_q;
endmodule
